// File: rtl/piso_pkg.sv
// Shared constants and helpers for the parallel-in/serial-out width converter.
package piso_pkg;

  localparam int unsigned DefaultInWidth  = 8;
  localparam int unsigned DefaultOutWidth = 2;

  function automatic int unsigned piso_beats(input int unsigned in_w, input int unsigned out_w);
    return in_w / out_w;
  endfunction

endpackage

// File: rtl/valid_ready_std_if.sv
// Standard valid/ready handshake bundle; the producer drives data/valid and the consumer drives ready.
interface valid_ready_std_if #(
  parameter int unsigned DATAWIDTH = 8
);

  logic [DATAWIDTH-1:0] data;
  logic                 valid;
  logic                 ready;

  modport in  (input data, input valid, output ready);
  modport out (output data, output valid, input ready);

endinterface

// File: rtl/piso_serializer.sv
// Splits each IN_WIDTH word into IN_WIDTH/OUT_WIDTH beats, MSB-first, and flags the final beat.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = DefaultInWidth,
  parameter int unsigned OUT_WIDTH = DefaultOutWidth
) (
  input  logic                   clk,
  input  logic                   rst_n,
  valid_ready_std_if.in          din,
  valid_ready_std_if.out         dout,
  output logic                   last
);

  localparam int unsigned BEATS = piso_beats(IN_WIDTH, OUT_WIDTH);
  localparam int unsigned CntW  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(BEATS - 1);

  logic                busy_q, busy_d;
  logic [IN_WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]     count_q, count_d;

  logic accept;
  logic beat_fire;

  assign last       = busy_q && (count_q == LastCnt);
  // The final beat frees the register on the same edge, so a new word loads without a bubble.
  assign din.ready  = !rst_n && (!busy_q || (last && dout.ready));
  assign dout.valid = busy_q;
  assign dout.data  = shift_q[IN_WIDTH-1 -: OUT_WIDTH];

  assign accept    = din.valid && din.ready;
  assign beat_fire = busy_q && dout.ready;

  always_comb begin
    busy_d  = busy_q;
    shift_d = shift_q;
    count_d = count_q;
    if (accept) begin
      busy_d  = 1'b1;
      shift_d = din.data;
      count_d = '0;
    end else if (beat_fire) begin
      if (count_q == LastCnt) begin
        busy_d = 1'b0;
      end else begin
        shift_d = shift_q << OUT_WIDTH;
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      busy_q  <= 1'b0;
      shift_q <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      shift_q <= shift_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed and random stimulus for piso_serializer against a queue-of-beats reference model.
module tb_piso_serializer;

  localparam int unsigned IW = 8;
  localparam int unsigned OW = 2;
  localparam int unsigned NB = IW / OW;

  typedef struct packed {
    logic [OW-1:0] data;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  logic last;

  valid_ready_std_if #(.DATAWIDTH(IW)) din_if ();
  valid_ready_std_if #(.DATAWIDTH(OW)) dout_if ();

  piso_serializer #(
    .IN_WIDTH (IW),
    .OUT_WIDTH(OW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (din_if),
    .dout (dout_if),
    .last (last)
  );

  always #5 clk = ~clk;

  beat_t       exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [IW-1:0] seen;
  int          n_beats;
  int          n_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    seen    = '0;
    n_beats = 0;
    n_last  = 0;
  endtask

  // Model: a word accepted at an edge becomes NB queued beats; each output handshake pops one.
  task automatic cycle(input logic v, input logic [IW-1:0] d, input logic r);
    int     n;
    logic   exp_rdy;
    logic   fire_out;
    logic   acc;
    logic [IW-1:0] tmp;
    beat_t  e;
    @(negedge clk);
    din_if.valid  = v;
    din_if.data   = d;
    dout_if.ready = r;
    #1;
    n = exp_q.size();
    if (n == 0) begin
      chk("valid_idle", 32'(dout_if.valid), 32'd0);
      chk("last_idle", 32'(last), 32'd0);
    end else begin
      chk("valid_busy", 32'(dout_if.valid), 32'd1);
      chk("beat_data", 32'(dout_if.data), 32'(exp_q[0].data));
      chk("beat_last", 32'(last), 32'(exp_q[0].last));
    end
    exp_rdy = (n == 0) || (n == 1 && r);
    chk("din_ready", 32'(din_if.ready), 32'(exp_rdy));
    fire_out = r && (n > 0);
    acc      = v && exp_rdy;
    @(posedge clk);
    if (fire_out) begin
      seen = {seen[IW-OW-1:0], exp_q[0].data};
      n_beats++;
      if (exp_q[0].last) n_last++;
      void'(exp_q.pop_front());
    end
    if (acc) begin
      for (int k = 0; k < int'(NB); k++) begin
        tmp    = d >> (IW - OW * (k + 1));
        e.data = tmp[OW-1:0];
        e.last = (k == int'(NB) - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(dout_if.valid), 32'd0);
    chk({tag, "_last"}, 32'(last), 32'd0);
    chk({tag, "_ready"}, 32'(din_if.ready), 32'd0);
    chk({tag, "_data"}, 32'(dout_if.data), 32'd0);
  endtask

  initial begin
    rst_n         = 1'b1;
    din_if.valid  = 1'b0;
    din_if.data   = '0;
    dout_if.ready = 1'b0;
    clear_log();

    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check_reset_outputs("rst");
    end
    @(negedge clk);
    rst_n = 1'b0;
    cycle(1'b0, 8'h00, 1'b0);

    // Single word, consumer always ready
    clear_log();
    cycle(1'b1, 8'hCD, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("cd_word", 32'(seen), 32'hCD);
    chk("cd_beats", 32'(n_beats), 32'd4);
    chk("cd_lasts", 32'(n_last), 32'd1);

    // Backpressure: low 3, high 3, low 3, then high
    clear_log();
    cycle(1'b1, 8'h27, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("bp_word", 32'(seen), 32'h27);
    chk("bp_beats", 32'(n_beats), 32'd4);

    // Streaming: 12 words accepted in 47 cycles, no bubbles
    clear_log();
    for (int i = 0; i < 47; i++) cycle(1'b1, 8'h27, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("stream_beats", 32'(n_beats), 32'd48);
    chk("stream_lasts", 32'(n_last), 32'd12);

    // Single-cycle valid pulse
    clear_log();
    cycle(1'b1, 8'hAD, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("pulse_word", 32'(seen), 32'hAD);
    chk("pulse_beats", 32'(n_beats), 32'd4);

    // Pulse accept with toggling ready, then a long idle stall
    clear_log();
    cycle(1'b1, 8'h5A, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, logic'(i % 2));
    chk("tog_word", 32'(seen), 32'h5A);
    chk("tog_lasts", 32'(n_last), 32'd1);
    for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00, 1'b0);

    // Reset mid-word: outputs drop immediately, nothing left afterwards
    cycle(1'b1, 8'h96, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    #1;
    chk("mid_valid_pre", 32'(dout_if.valid), 32'd1);
    rst_n = 1'b1;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b0;
    clear_log();
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("midrst_beats", 32'(n_beats), 32'd0);

    // Random traffic on both sides
    for (int i = 0; i < 400; i++) begin
      cycle(logic'($urandom_range(0, 1)), IW'($urandom), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("rand_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out width converter with valid/ready handshakes on both sides.
- Accepts one IN_WIDTH word and emits it as IN_WIDTH/OUT_WIDTH narrower beats, MSB-first.
- Flags the final beat of each word with last.
- Sits between a byte-wide producer and a narrow downstream link; both sides use the team's valid_ready_std_if bundle.

Parameters:
- IN_WIDTH, 8, input word width; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 2, output beat width.
- BEATS, IN_WIDTH/OUT_WIDTH (derived localparam, 4), beats per word.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-high reset (port keeps codebase name; asserted = 1).
- din.data  input  IN_WIDTH  parallel word (valid_ready_std_if, in modport, DATAWIDTH=IN_WIDTH).
- din.valid  input  1  producer has a word.
- din.ready  output  1  block can accept a word this cycle.
- dout.data  output  OUT_WIDTH  current beat (valid_ready_std_if, out modport, DATAWIDTH=OUT_WIDTH).
- dout.valid  output  1  beat available.
- dout.ready  input  1  consumer accepts beat.
- last  output  1  high together with dout.valid on the final beat of a word.

Behaviour:
- State: busy flag, IN_WIDTH shift register, beat counter of width clog2(BEATS).
- Reset, asynchronous on rst_n=1:
  - busy=0, shift=0, count=0.
  - dout.valid=0, dout.data=0, last=0.
  - din.ready is forced 0 while reset is asserted.
- dout.valid = busy. dout.data = shift[IN_WIDTH-1 -: OUT_WIDTH].
- last = busy && count==BEATS-1.
- Input accept (din.valid && din.ready at an edge):
  - shift <= din.data, count <= 0, busy <= 1.
  - First beat is visible the cycle after acceptance (1-cycle latency).
- Output beat (dout.valid && dout.ready at an edge):
  - If count<BEATS-1: shift <<= OUT_WIDTH, count++.
  - If count==BEATS-1: word done; busy <= 0 unless a new word is accepted the same edge.
- din.ready (combinational) = !busy || (last && dout.ready). This gives back-to-back words with no bubble.
- Sustained throughput with dout.ready held high: one word per BEATS cycles, one beat per cycle.
- Output stall (dout.ready=0):
  - dout.data, dout.valid, last and count hold.
  - din.ready=0 while busy.
  - din.valid and din.data are ignored; the producer must hold them.
- din.valid may drop at any time; no beat is produced from a non-accepted word.
- Simultaneous final-beat handshake and new-word accept: the new word loads, and its first beat appears the next cycle.
- Reset mid-word: the partial word is discarded, and outputs immediately go to their reset values.
- No X propagation into state when din.valid=0.

Decomposition:
- Package piso_pkg: default IN_WIDTH/OUT_WIDTH constants and a BEATS helper function.
- Interface valid_ready_std_if is a shared file:
  - Parameter DATAWIDTH; signals data, valid, ready.
  - Modport in: data/valid input, ready output.
  - Modport out: data/valid output, ready input.
- A single module is sufficient; the optional counter is inlined. No further sub-modules.

Test Plan:
- Reset: rst_n=1 for 3 cycles -> dout.valid=0, last=0, din.ready=0. After release, din.ready=1 and dout.valid=0.
- Single word 0xCD, dout.ready=1 -> beats 2'b11,2'b00,2'b11,2'b01 on 4 consecutive cycles starting 1 cycle after accept. last only on 2'b01. din.ready returns 1 on the last beat.
- Backpressure: word 0x27 accepted, dout.ready low 3 cycles, high 3, low 3, then high -> beats 2'b00,2'b10,2'b01,2'b11 with data/last held during stalls. Nothing lost or duplicated, and din.ready=0 throughout the stalls.
- Streaming: din.valid=1 with constant 0x27 for 47 cycles, dout.ready=1 -> continuous beats, no bubble between words, last every 4th cycle.
- Single-cycle valid pulse with 0xAD after idle -> exactly one word emitted: 2'b10,2'b10,2'b11,2'b01. dout.valid falls after the last beat.
- Pulse accept, then dout.ready toggling 0/1/0/1 -> beat order preserved and last asserted exactly once. Finally dout.ready=0 for 20 cycles with nothing pending -> dout.valid stays 0.
- Reset asserted mid-word -> dout.valid and last drop immediately; after release, no residual beats.
